traffic_cmd_parser: RTL and testbench



---
 rtl/traffic_cmd_parser.sv | 176 +++++++++++++++++
 tb/tb_traffic_cmd_parser.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_cmd_parser.sv
// Byte-stream frame parser feeding the traffic-light controller command port.
// Optional checksum byte enabled by defining TRAFFIC_CMD_CHECKSUM_EN.
module traffic_cmd_parser #(
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
    parameter int unsigned TIMEOUT_CLK  = 200,
    parameter int unsigned MAX_CMD_TYPE = 5
) (
    input  logic        clk_0m002,
    input  logic        srst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_val_i,
    output logic        rx_rdy_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_val_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StType, StDataHi, StDataLo, StCsum, StEmit} state_e;
`else
    typedef enum logic [2:0] {StIdle, StType, StDataHi, StDataLo, StEmit} state_e;
`endif

    localparam bit          TmoEn   = (TIMEOUT_CLK != 0);
    localparam logic [15:0] TmoLast = TmoEn ? 16'(TIMEOUT_CLK - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [2:0]  cmd_type_q, cmd_type_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    logic [7:0]  data_lo_q, data_lo_d;
    logic [7:0]  csum_exp;
`endif

    logic rdy;
    logic xfer;
    logic type_legal;
    logic in_frame;
    logic tmo_hit;
    logic err;

    assign rdy        = (state_q != StEmit);
    assign xfer       = rx_val_i && rdy;
    assign type_legal = (rx_data_i[7:3] == 5'b0) && (32'(rx_data_i[2:0]) <= MAX_CMD_TYPE);
    assign in_frame   = (state_q != StIdle) && (state_q != StEmit);
    assign tmo_hit    = TmoEn && in_frame && (tmo_q == TmoLast) && !xfer;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    assign csum_exp   = {5'b0, type_q} ^ data_hi_q ^ data_lo_q;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        data_hi_d  = data_hi_q;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        tmo_d      = 16'd0;
        err        = 1'b0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        data_lo_d  = data_lo_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Non-header bytes are line noise: drop them without flagging.
                if (xfer && (rx_data_i == HEADER_BYTE)) begin
                    state_d = StType;
                end
            end
            StType: begin
                if (xfer) begin
                    if (type_legal) begin
                        type_d  = rx_data_i[2:0];
                        state_d = StDataHi;
                    end else begin
                        err     = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDataHi: begin
                if (xfer) begin
                    data_hi_d = rx_data_i;
                    state_d   = StDataLo;
                end
            end
            StDataLo: begin
                if (xfer) begin
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                    data_lo_d  = rx_data_i;
                    state_d    = StCsum;
`else
                    cmd_type_d = type_q;
                    cmd_data_d = {data_hi_q, rx_data_i};
                    state_d    = StEmit;
`endif
                end
            end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    if (rx_data_i == csum_exp) begin
                        cmd_type_d = type_q;
                        cmd_data_d = {data_hi_q, data_lo_q};
                        state_d    = StEmit;
                    end else begin
                        err     = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StEmit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An accepted byte always beats expiry in the same cycle.
        if (in_frame && !xfer) begin
            if (tmo_hit) begin
                err     = 1'b1;
                state_d = StIdle;
            end else if (TmoEn) begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        err_cnt_d = err_cnt_q;
        if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_0m002) begin
        if (!srst_n_i) begin
            state_q    <= StIdle;
            type_q     <= 3'd0;
            data_hi_q  <= 8'd0;
            cmd_type_q <= 3'd0;
            cmd_data_q <= 16'd0;
            tmo_q      <= 16'd0;
            err_cnt_q  <= 8'd0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            data_lo_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            data_hi_q  <= data_hi_d;
            cmd_type_q <= cmd_type_d;
            cmd_data_q <= cmd_data_d;
            tmo_q      <= tmo_d;
            err_cnt_q  <= err_cnt_d;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            data_lo_q  <= data_lo_d;
`endif
        end
    end

    assign rx_rdy_o   = rdy;
    assign cmd_type_o = cmd_type_q;
    assign cmd_data_o = cmd_data_q;
    assign cmd_val_o  = (state_q == StEmit);
    assign err_o      = err;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_traffic_cmd_parser.sv
// Scoreboard bench for traffic_cmd_parser; follows TRAFFIC_CMD_CHECKSUM_EN if defined.
module tb_traffic_cmd_parser;

    logic        clk_0m002 = 1'b0;
    logic        srst_n_i  = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_val_i  = 1'b0;
    logic        rx_rdy_o;
    logic [2:0]  cmd_type_o;
    logic [15:0] cmd_data_o;
    logic        cmd_val_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    localparam int FrameLen = 5;
`else
    localparam int FrameLen = 4;
`endif

    int total    = 0;
    int bad      = 0;
    int err_seen = 0;
    int cyc      = 0;
    int exp_errs = 0;
    logic [18:0] exp_q[$];

    traffic_cmd_parser dut (
        .clk_0m002  (clk_0m002),
        .srst_n_i   (srst_n_i),
        .rx_data_i  (rx_data_i),
        .rx_val_i   (rx_val_i),
        .rx_rdy_o   (rx_rdy_o),
        .cmd_type_o (cmd_type_o),
        .cmd_data_o (cmd_data_o),
        .cmd_val_o  (cmd_val_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_0m002 = ~clk_0m002;

    always @(posedge clk_0m002) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every strobe, mid-cycle.
    always @(negedge clk_0m002) begin
        if (srst_n_i) begin
            if (err_o) err_seen = err_seen + 1;
            if (cmd_val_o) begin
                total = total + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_cmd got type=%0d data=%h want none",
                             cmd_type_o, cmd_data_o);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    if ({cmd_type_o, cmd_data_o} !== e) begin
                        bad = bad + 1;
                        $display("FAIL cmd_payload got type=%0d data=%h want type=%0d data=%h",
                                 cmd_type_o, cmd_data_o, e[18:16], e[15:0]);
                    end
                end
            end
            total = total + 1;
            if ((err_o && cmd_val_o) !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL err_and_val got err=%b val=%b want not both", err_o, cmd_val_o);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_0m002);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        rx_data_i = b;
        rx_val_i  = 1'b1;
        while (!rx_rdy_o && w < 8) begin
            @(posedge clk_0m002);
            #1;
            w++;
        end
        total++;
        if (rx_rdy_o !== 1'b1) begin
            bad++;
            $display("FAIL send_ready got rdy=%b want 1 (byte %h)", rx_rdy_o, b);
        end
        @(posedge clk_0m002);
        #1;
        rx_val_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] hi, input logic [7:0] lo);
        send(8'hA5);
        send(t);
        send(hi);
        send(lo);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send(t ^ hi ^ lo);
`endif
    endtask

    task automatic chk_cnt(input string name);
        total++;
        if (err_cnt_o !== 8'(exp_errs)) begin
            bad++;
            $display("FAIL %s err_cnt got %0d want %0d", name, err_cnt_o, exp_errs);
        end
    endtask

    task automatic test_reset;
        srst_n_i = 1'b0;
        idle(2);
        total++;
        if ({cmd_type_o, cmd_data_o, cmd_val_o, err_o, err_cnt_o, rx_rdy_o} !== 30'd1) begin
            bad++;
            $display("FAIL reset_values got type=%0d data=%h val=%b err=%b cnt=%0d rdy=%b want 0s rdy=1",
                     cmd_type_o, cmd_data_o, cmd_val_o, err_o, err_cnt_o, rx_rdy_o);
        end
        srst_n_i = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        exp_q.push_back({3'd3, 16'h01F4});
        send_frame(8'h03, 8'h01, 8'hF4);
        total++;
        if ({cmd_val_o, rx_rdy_o, cmd_type_o, cmd_data_o} !== {1'b1, 1'b0, 3'd3, 16'h01F4}) begin
            bad++;
            $display("FAIL basic_emit got val=%b rdy=%b type=%0d data=%h want 1 0 3 01f4",
                     cmd_val_o, rx_rdy_o, cmd_type_o, cmd_data_o);
        end
        chk_cnt("basic");
        idle(1);
        total++;
        if ({cmd_val_o, cmd_type_o, cmd_data_o} !== {1'b0, 3'd3, 16'h01F4}) begin
            bad++;
            $display("FAIL basic_hold got val=%b type=%0d data=%h want 0 3 01f4",
                     cmd_val_o, cmd_type_o, cmd_data_o);
        end
    endtask

    task automatic test_noise;
        int e0;
        e0 = err_seen;
        send(8'h00);
        send(8'hFF);
        send(8'h13);
        exp_q.push_back({3'd0, 16'h0000});
        send_frame(8'h00, 8'h00, 8'h00);
        idle(2);
        total++;
        if (err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL noise_err got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_bad_type;
        int e0;
        e0 = err_seen;
        send(8'hA5); send(8'h06);
        send(8'hA5); send(8'h09);
        send(8'hA5); send(8'hA5);
        exp_errs += 3;
        idle(2);
        total++;
        if (err_seen - e0 !== 3) begin
            bad++;
            $display("FAIL bad_type_err got %0d pulses want 3", err_seen - e0);
        end
        chk_cnt("bad_type");
    endtask

    task automatic test_timeout;
        int  e0;
        bit  early;
        e0 = err_seen;
        early = 1'b0;
        send(8'hA5);
        send(8'h04);
        for (int k = 1; k < 200; k++) begin
            @(negedge clk_0m002);
            if (err_o) early = 1'b1;
            @(posedge clk_0m002);
            #1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got err before cycle 200 want none");
        end
        @(negedge clk_0m002);
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got err=%b want 1 in idle cycle 200", err_o);
        end
        @(posedge clk_0m002);
        #1;
        exp_errs++;
        exp_q.push_back({3'd1, 16'hABCD});
        send_frame(8'h01, 8'hAB, 8'hCD);
        chk_cnt("timeout");

        e0 = err_seen;
        send(8'hA5);
        send(8'h04);
        idle(199);
        exp_q.push_back({3'd4, 16'h5678});
        send(8'h56);
        send(8'h78);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send(8'h04 ^ 8'h56 ^ 8'h78);
`endif
        idle(2);
        total++;
        if (err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL timeout_race got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        exp_q.push_back({3'd2, 16'h1111});
        exp_q.push_back({3'd5, 16'h2222});
        exp_q.push_back({3'd1, 16'h3333});
        c0 = cyc;
        send_frame(8'h02, 8'h11, 8'h11);
        send_frame(8'h05, 8'h22, 8'h22);
        send_frame(8'h01, 8'h33, 8'h33);
        total++;
        if (cyc - c0 !== 3 * FrameLen + 2) begin
            bad++;
            $display("FAIL back_to_back_cycles got %0d want %0d", cyc - c0, 3 * FrameLen + 2);
        end
        idle(2);
    endtask

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    task automatic test_checksum;
        int e0;
        exp_q.push_back({3'd5, 16'h1234});
        send(8'hA5); send(8'h05); send(8'h12); send(8'h34); send(8'h23);
        e0 = err_seen;
        idle(1);
        send(8'hA5); send(8'h05); send(8'h12); send(8'h34); send(8'h00);
        exp_errs++;
        idle(2);
        total++;
        if ({err_seen - e0, cmd_type_o, cmd_data_o} !== {32'd1, 3'd5, 16'h1234}) begin
            bad++;
            $display("FAIL checksum_bad got pulses=%0d type=%0d data=%h want 1 5 1234",
                     err_seen - e0, cmd_type_o, cmd_data_o);
        end
        chk_cnt("checksum");
    endtask
`endif

    task automatic test_saturate_and_reset;
        int e0;
        e0 = err_seen;
        repeat (260) begin
            send(8'hA5);
            send(8'h07);
        end
        exp_errs = (exp_errs + 260 > 255) ? 255 : exp_errs + 260;
        idle(1);
        total++;
        if (err_seen - e0 !== 260) begin
            bad++;
            $display("FAIL sat_pulses got %0d want 260", err_seen - e0);
        end
        chk_cnt("saturate");

        send(8'hA5);
        send(8'h02);
        srst_n_i = 1'b0;
        idle(1);
        total++;
        if ({cmd_type_o, cmd_data_o, cmd_val_o, err_o, err_cnt_o, rx_rdy_o} !== 30'd1) begin
            bad++;
            $display("FAIL midframe_reset got type=%0d data=%h val=%b err=%b cnt=%0d rdy=%b want 0s rdy=1",
                     cmd_type_o, cmd_data_o, cmd_val_o, err_o, err_cnt_o, rx_rdy_o);
        end
        srst_n_i = 1'b1;
        exp_errs = 0;
        idle(1);
        exp_q.push_back({3'd2, 16'hBEEF});
        send_frame(8'h02, 8'hBE, 8'hEF);
        total++;
        if ({cmd_val_o, cmd_type_o, cmd_data_o} !== {1'b1, 3'd2, 16'hBEEF}) begin
            bad++;
            $display("FAIL post_reset_frame got val=%b type=%0d data=%h want 1 2 beef",
                     cmd_val_o, cmd_type_o, cmd_data_o);
        end
        idle(2);
        chk_cnt("post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish within 1ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_noise();
        test_bad_type();
        test_timeout();
        test_back_to_back();
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_saturate_and_reset();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL missing_cmds got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
